// File: rtl/cos_pkg.sv
// Shared types for the cos(x) Taylor-series controller, datapath and bench.
package cos_pkg;

  localparam int COS_X_W = 16;
  localparam int COS_Y_W = 8;

  typedef enum logic [2:0] {
    IDLE, INIT, LOAD, SQUARE, COEF, ACCUM, CHECK, DONE
  } cos_state_t;

  typedef struct packed {
    logic init_pp;
    logic init_ps;
    logic init_cnt;
    logic init_DFF;
    logic ld_y;
    logic ld_x2;
    logic sel_x;
    logic inc_cnt;
    logic sel_x2;
    logic sel_pp;
    logic ld_pp;
    logic sel_ROM;
    logic ld_ps;
    logic toggle;
  } cos_ctrl_t;

endpackage

// File: rtl/cos_dp_controller_if.sv
// Operand-in / result-out handshake bundle of the cos controller.
// valid/ready: a transfer happens on a rising clk edge where valid & ready are both 1;
// the source holds valid and its payload stable until that edge.
interface cos_dp_controller_if;
  import cos_pkg::*;

  logic               start_valid;
  logic               start_ready;
  logic [COS_X_W-1:0] x_in;
  logic [COS_Y_W-1:0] y_in;
  logic               abort;
  logic               res_valid;
  logic               res_ready;
  logic [COS_X_W-1:0] res_data;
  logic               res_limit;

  modport master (
    output start_valid, x_in, y_in, abort, res_ready,
    input  start_ready, res_valid, res_data, res_limit
  );

  modport slave (
    input  start_valid, x_in, y_in, abort, res_ready,
    output start_ready, res_valid, res_data, res_limit
  );

endinterface

// File: rtl/cos_ctrl_decode.sv
// Moore decode of controller state into the 14 datapath strobes.
module cos_ctrl_decode
  import cos_pkg::*;
(
  input  cos_state_t state,
  output cos_ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      INIT: begin
        ctrl.init_pp  = 1'b1;
        ctrl.init_ps  = 1'b1;
        ctrl.init_cnt = 1'b1;
        ctrl.init_DFF = 1'b1;
      end
      LOAD: begin
        ctrl.ld_y  = 1'b1;
        ctrl.ld_x2 = 1'b1;
        ctrl.sel_x = 1'b1;
      end
      SQUARE: begin
        ctrl.sel_x2  = 1'b1;
        ctrl.sel_pp  = 1'b1;
        ctrl.ld_pp   = 1'b1;
        ctrl.inc_cnt = 1'b1;
      end
      COEF: begin
        ctrl.sel_ROM = 1'b1;
        ctrl.sel_pp  = 1'b1;
        ctrl.ld_pp   = 1'b1;
      end
      ACCUM: begin
        ctrl.ld_ps  = 1'b1;
        ctrl.toggle = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/cos_dp_controller.sv
// Control FSM for the cos(x) datapath: takes an operand, runs one series term per
// loop pass, stops on convergence / carry-out / term limit, holds the result.
module cos_dp_controller
  import cos_pkg::*;
#(
  parameter int MAX_TERMS = 8
) (
  input  logic               clk,
  input  logic               rst,
  cos_dp_controller_if.slave host,
  output logic [COS_X_W-1:0] dp_x,
  output logic [COS_Y_W-1:0] dp_y,
  input  logic [COS_X_W-1:0] cos_bus,
  input  logic               cnt_co,
  input  logic               not_continue,
  output logic               init_pp,
  output logic               init_ps,
  output logic               init_cnt,
  output logic               init_DFF,
  output logic               ld_y,
  output logic               ld_x2,
  output logic               sel_x,
  output logic               inc_cnt,
  output logic               sel_x2,
  output logic               sel_pp,
  output logic               ld_pp,
  output logic               sel_ROM,
  output logic               ld_ps,
  output logic               toggle,
  output cos_state_t         state_dbg
);

  localparam int ITER_W = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_TERMS - 1);

  cos_state_t         state, state_next;
  cos_ctrl_t          ctrl;
  logic [ITER_W-1:0]  iter;
  logic               ready_q;
  logic               res_valid_q;
  logic [COS_X_W-1:0] res_data_q;
  logic               res_limit_q;
  logic               accept, stop, abort_run, res_take;

  assign accept    = ready_q && host.start_valid && !host.abort;
  assign stop      = not_continue || cnt_co || (iter == ITER_LAST);
  assign abort_run = host.abort && (state != IDLE);
  assign res_take  = (state == DONE) && res_valid_q && host.res_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = INIT;
      INIT:    state_next = LOAD;
      LOAD:    state_next = SQUARE;
      SQUARE:  state_next = COEF;
      COEF:    state_next = ACCUM;
      ACCUM:   state_next = CHECK;
      CHECK:   state_next = stop ? DONE : SQUARE;
      DONE:    if (res_take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_run) state_next = IDLE;
  end

  cos_ctrl_decode u_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  assign {init_pp, init_ps, init_cnt, init_DFF, ld_y, ld_x2, sel_x, inc_cnt,
          sel_x2, sel_pp, ld_pp, sel_ROM, ld_ps, toggle} = ctrl;
  assign state_dbg        = state;
  assign host.start_ready = ready_q;
  assign host.res_valid   = res_valid_q;
  assign host.res_data    = res_data_q;
  assign host.res_limit   = res_limit_q;

  // ready is registered so it stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q     <= 1'b0;
      dp_x        <= '0;
      dp_y        <= '0;
      iter        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_limit_q <= 1'b0;
    end else begin
      ready_q <= (state_next == IDLE);
      if (accept) begin
        dp_x <= host.x_in;
        dp_y <= host.y_in;
        iter <= '0;
      end
      if (state == CHECK && !host.abort) begin
        if (stop) begin
          res_data_q  <= cos_bus;
          res_limit_q <= ~(not_continue | cnt_co);
          res_valid_q <= 1'b1;
        end else begin
          iter <= iter + ITER_W'(1);
        end
      end
      if (res_take || abort_run) res_valid_q <= 1'b0;
    end
  end

endmodule
